// File: rtl/datapath_pkg.sv
// datapath_pkg: register-file widths and types shared by the operand select, register bank and writeback stages
package datapath_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREG   = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0]      reg_addr_t;
    typedef logic [DATA_W-1:0]      reg_data_t;
    typedef logic [NREG-1:0]        reg_mask_t;
    typedef reg_data_t [NREG-1:0]   reg_file_t;
endpackage

// File: rtl/reg_bank_read_port.sv
// reg_bank_read_port: combinational 16:1 register select with same-cycle write bypass and busy lookup
//   regs/rsv           : current storage and reservation state
//   addr               : source register
//   wr_en/wr_addr/data : writeback in flight this cycle (bypass source)
//   data               : selected operand, bypassed when the writeback targets addr
//   busy               : reservation still pending after this cycle's writeback
module reg_bank_read_port
    import datapath_pkg::*;
(
    input  reg_file_t regs,
    input  reg_mask_t rsv,
    input  reg_addr_t addr,
    input  logic      wr_en,
    input  reg_addr_t wr_addr,
    input  reg_data_t wr_data,
    output reg_data_t data,
    output logic      busy
);
    logic hit;

    always_comb begin
        hit  = wr_en && (wr_addr == addr);
        data = hit ? wr_data : regs[addr];
        busy = rsv[addr] && !hit;
    end
endmodule

// File: rtl/reg_bank16.sv
// reg_bank16: 16x16 register bank with two registered read ports, write bypass and a reservation scoreboard
//   rd_req/rd_addr_a/rd_addr_b -> rd_ready (comb), rd_valid/rd_data_a/rd_data_b (registered, 1-cycle latency)
//   rsv_en/rsv_addr            : reserve a destination register; rsv_err pulses on double reservation
//   wr_en/wr_addr/wr_data      : writeback, clears the reservation of wr_addr
//   busy_mask                  : raw reservation state
module reg_bank16
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [NREG-1:0]   busy_mask,
    output logic              rsv_err
);
    reg_file_t regs_q, regs_d;
    reg_mask_t rsv_q, rsv_d;
    reg_data_t rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
    reg_data_t data_a, data_b;
    logic      rd_valid_q, rd_valid_d, rsv_err_q, rsv_err_d;
    logic      busy_a, busy_b, accept;

    reg_bank_read_port u_port_a (
        .regs(regs_q), .rsv(rsv_q), .addr(rd_addr_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .data(data_a), .busy(busy_a)
    );

    reg_bank_read_port u_port_b (
        .regs(regs_q), .rsv(rsv_q), .addr(rd_addr_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .data(data_b), .busy(busy_b)
    );

    always_comb begin
        rd_ready    = !(busy_a || busy_b);
        accept      = rd_req && rd_ready;
        rd_valid_d  = accept;
        rd_data_a_d = accept ? data_a : rd_data_a_q;
        rd_data_b_d = accept ? data_b : rd_data_b_q;
        regs_d      = regs_q;
        rsv_d       = rsv_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
            rsv_d[wr_addr]  = 1'b0;
        end
        // reservation is ordered after a same-edge write, so it wins
        if (rsv_en)
            rsv_d[rsv_addr] = 1'b1;
        // a bit retired by this cycle's writeback is not a double reservation
        rsv_err_d = rsv_en && rsv_q[rsv_addr] && !(wr_en && (wr_addr == rsv_addr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q      <= '0;
            rsv_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rsv_err_q   <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            rsv_q       <= rsv_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            rsv_err_q   <= rsv_err_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign busy_mask = rsv_q;
    assign rsv_err   = rsv_err_q;
endmodule

// File: tb/tb_reg_bank16.sv
// tb_reg_bank16: directed stimulus with a read-data scoreboard for reg_bank16
module tb_reg_bank16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_req = 1'b0;
    logic [3:0]  rd_addr_a = '0, rd_addr_b = '0;
    logic        rd_ready, rd_valid;
    logic [15:0] rd_data_a, rd_data_b;
    logic        rsv_en = 1'b0;
    logic [3:0]  rsv_addr = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] busy_mask;
    logic        rsv_err;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    reg_bank16 dut (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_mask(busy_mask), .rsv_err(rsv_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_req = 1'b0;
        rsv_en = 1'b0;
        wr_en  = 1'b0;
    endtask

    // issue a read expected to be accepted this cycle, queueing its result
    task automatic rd(input logic [3:0] a, input logic [3:0] b, input logic [15:0] ea, input logic [15:0] eb);
        rd_req = 1'b1;
        rd_addr_a = a;
        rd_addr_b = b;
        #1;
        chk("rd_ready", {31'd0, rd_ready}, 32'd1);
        exp_q.push_back({ea, eb});
    endtask

    // monitor: every rd_valid beat must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_valid_unexpected: got data 0x%0h_%0h with empty queue", rd_data_a, rd_data_b);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("rd_data", {rd_data_a, rd_data_b}, e);
            end
        end
    end

    initial begin
        repeat (2) tick();
        chk("rst_busy", {16'd0, busy_mask}, 32'd0);
        chk("rst_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_data", {rd_data_a, rd_data_b}, 32'd0);
        chk("rst_err", {31'd0, rsv_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        rd(4'd3, 4'd7, 16'h0000, 16'h0000);
        tick(); idle();

        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
        rd(4'd5, 4'd5, 16'hBEEF, 16'hBEEF);
        tick(); idle();

        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'hA5A5;
        tick(); idle();

        rsv_en = 1'b1; rsv_addr = 4'd9;
        tick(); idle();
        rd_req = 1'b1; rd_addr_a = 4'd9; rd_addr_b = 4'd0;
        #1;
        chk("rd_ready_busy", {31'd0, rd_ready}, 32'd0);
        chk("busy_r9", {16'd0, busy_mask}, 32'h0200);
        tick();
        chk("no_valid_blocked", {31'd0, rd_valid}, 32'd0);
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h1234;
        rd(4'd9, 4'd0, 16'h1234, 16'h0000);
        tick(); idle();
        chk("busy_cleared", {16'd0, busy_mask}, 32'h0000);

        rd(4'd9, 4'd5, 16'h1234, 16'hBEEF);
        tick();
        rd(4'd5, 4'd6, 16'hBEEF, 16'hA5A5);
        tick();
        rd(4'd6, 4'd9, 16'hA5A5, 16'h1234);
        tick();
        rd(4'd0, 4'd3, 16'h0000, 16'h0000);
        tick(); idle();
        tick();
        chk("valid_drops", {31'd0, rd_valid}, 32'd0);
        chk("data_hold", {rd_data_a, rd_data_b}, 32'h0000_0000);

        rsv_en = 1'b1; rsv_addr = 4'd2;
        tick();
        chk("err_first_rsv", {31'd0, rsv_err}, 32'd0);
        tick(); idle();
        chk("err_double_rsv", {31'd0, rsv_err}, 32'd1);
        chk("busy_r2", {16'd0, busy_mask}, 32'h0004);
        tick();
        chk("err_one_cycle", {31'd0, rsv_err}, 32'd0);

        rsv_en = 1'b1; rsv_addr = 4'd4;
        tick();
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h00FF;
        tick(); idle();
        chk("busy_r4_kept", {16'd0, busy_mask}, 32'h0014);
        chk("err_wr_rsv_same", {31'd0, rsv_err}, 32'd0);
        rd_req = 1'b1; rd_addr_a = 4'd4; rd_addr_b = 4'd2;
        #1;
        chk("rd_ready_r4", {31'd0, rd_ready}, 32'd0);
        idle();

        rsv_en = 1'b1; rsv_addr = 4'd1;
        rd(4'd5, 4'd6, 16'hBEEF, 16'hA5A5);
        tick(); idle();
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {16'd0, busy_mask}, 32'd0);
        chk("arst_valid", {31'd0, rd_valid}, 32'd0);
        chk("arst_data", {rd_data_a, rd_data_b}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        rd(4'd1, 4'd5, 16'h0000, 16'h0000);
        tick(); idle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
